// File: rtl/deg_pkg.sv
// deg_pkg: shared widths and FSM states for the degree display path.
// Revision 1.0
`default_nettype none

package deg_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CAL  = 2'd1,
      END  = 2'd2
   } state_t;

   localparam int DEG_W      = 14;
   localparam int BCD_DIGITS = 5;
   localparam int BCD_W      = 4 * BCD_DIGITS;

endpackage

`default_nettype wire

// File: rtl/bcd_add3.sv
// bcd_add3: double-dabble nibble correction, adds 3 when the digit is 5 or more.
// Revision 1.0
`default_nettype none

module bcd_add3 (
   input  logic [3:0] i_nib,
   output logic [3:0] o_nib
);

   // Largest input 9 maps to 12, so the 4-bit sum never wraps.
   always_comb begin
      o_nib = (i_nib >= 4'd5) ? (i_nib + 4'd3) : i_nib;
   end

endmodule

`default_nettype wire

// File: rtl/deg2bcd.sv
// deg2bcd: iterative binary-to-BCD converter (one bit per clock) with leading-zero blank mask.
// Revision 1.0
`default_nettype none

module deg2bcd
   import deg_pkg::*;
#(
   parameter int DATA_W = DEG_W,
   parameter int DIGITS = BCD_DIGITS
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_start,
   input  logic [DATA_W-1:0]     i_deg,
   output logic [4*DIGITS-1:0]   o_bcd,
   output logic [DIGITS-1:0]     o_blank,
   output logic                  o_busy,
   output logic                  o_finished
);

   localparam int BCDW  = 4 * DIGITS;
   localparam int SHW   = BCDW + DATA_W;
   localparam int CNT_W = $clog2(DATA_W + 1);
   localparam logic [DIGITS-1:0] BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};

   state_t              state_q, state_d;
   logic [SHW-1:0]      shift_q, shift_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [BCDW-1:0]     bcd_q, bcd_d;
   logic [DIGITS-1:0]   blank_q, blank_d;
   logic                busy_q, busy_d;
   logic                finished_q, finished_d;

   logic [BCDW-1:0]     adj_bcd;
   logic [BCDW-1:0]     final_bcd;
   logic [DIGITS-1:0]   mask;
   logic                zero_run;

   generate
      for (genvar g = 0; g < DIGITS; g++) begin : g_add3
         bcd_add3 u_add3 (
            .i_nib (shift_q[DATA_W + 4*g +: 4]),
            .o_nib (adj_bcd[4*g +: 4])
         );
      end
   endgenerate

   assign final_bcd = shift_q[SHW-1:DATA_W];

   // A digit blanks while it and every digit above it is zero; digit 0 always shows.
   always_comb begin
      mask     = '0;
      zero_run = 1'b1;
      for (int n = DIGITS - 1; n >= 1; n--) begin
         zero_run = zero_run & (final_bcd[4*n +: 4] == 4'd0);
         mask[n]  = zero_run;
      end
   end

   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      cnt_d      = cnt_q;
      bcd_d      = bcd_q;
      blank_d    = blank_q;
      busy_d     = busy_q;
      finished_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (i_start) begin
               shift_d = {{BCDW{1'b0}}, i_deg};
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = CAL;
            end
         end
         CAL: begin
            if (cnt_q == CNT_W'(DATA_W)) begin
               bcd_d      = final_bcd;
               blank_d    = mask;
               finished_d = 1'b1;
               state_d    = END;
            end else begin
               shift_d = {adj_bcd, shift_q[DATA_W-1:0]} << 1;
               cnt_d   = cnt_q + CNT_W'(1);
            end
         end
         END: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q    <= IDLE;
         shift_q    <= '0;
         cnt_q      <= '0;
         bcd_q      <= '0;
         blank_q    <= BLANK_RST;
         busy_q     <= 1'b0;
         finished_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         cnt_q      <= cnt_d;
         bcd_q      <= bcd_d;
         blank_q    <= blank_d;
         busy_q     <= busy_d;
         finished_q <= finished_d;
      end
   end

   assign o_bcd      = bcd_q;
   assign o_blank    = blank_q;
   assign o_busy     = busy_q;
   assign o_finished = finished_q;

endmodule

`default_nettype wire

// File: tb/tb_deg2bcd.sv
// tb_deg2bcd: directed vector table, multi-cycle corner sequences and a randomized upstream chain.
`default_nettype none

module tb_deg2bcd;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b0;
   logic        i_start = 1'b0;
   logic [13:0] i_deg = '0;
   logic [19:0] o_bcd;
   logic [4:0]  o_blank;
   logic        o_busy;
   logic        o_finished;

   int checks = 0;
   int errors = 0;
   logic [19:0] last_bcd = '0;
   logic [4:0]  last_blank = 5'b11110;

   deg2bcd dut (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_start    (i_start),
      .i_deg      (i_deg),
      .o_bcd      (o_bcd),
      .o_blank    (o_blank),
      .o_busy     (o_busy),
      .o_finished (o_finished)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      logic [13:0] deg;
      logic [19:0] bcd;
      logic [4:0]  blank;
   } vec_t;

   function automatic logic [19:0] bcd_ref(input int unsigned v);
      logic [19:0] r;
      int unsigned x;
      r = '0;
      x = v;
      for (int i = 0; i < 5; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   function automatic logic [4:0] blank_ref(input logic [19:0] b);
      logic [4:0] m;
      logic z;
      m = '0;
      z = 1'b1;
      for (int n = 4; n >= 1; n--) begin
         if (b[4*n +: 4] != 4'd0) z = 1'b0;
         m[n] = z;
      end
      return m;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Pulse start for one edge, then wait for the result; checks latency, hold, values and pulse width.
   task automatic run(input logic [13:0] deg, input logic [19:0] exp_bcd, input logic [4:0] exp_blank,
                      input string tag);
      int n;
      logic seen;
      @(negedge i_clk);
      i_start = 1'b1;
      i_deg   = deg;
      @(posedge i_clk);
      #1;
      i_start = 1'b0;
      i_deg   = 14'bx;
      seen = 1'b0;
      n = 0;
      while (!seen && n < 40) begin
         @(posedge i_clk);
         #1;
         n++;
         if (n == 7) begin
            chk({tag, " hold bcd"}, 32'(o_bcd), 32'(last_bcd));
            chk({tag, " busy"}, 32'(o_busy), 32'd1);
         end
         if (o_finished) seen = 1'b1;
      end
      chk({tag, " latency"}, 32'(n), 32'd15);
      chk({tag, " bcd"}, 32'(o_bcd), 32'(exp_bcd));
      chk({tag, " blank"}, 32'(o_blank), 32'(exp_blank));
      @(posedge i_clk);
      #1;
      chk({tag, " pulse width"}, 32'(o_finished), 32'd0);
      last_bcd   = exp_bcd;
      last_blank = exp_blank;
   endtask

   vec_t vecs[9];

   initial begin
      int pulses;
      vecs[0] = '{14'd359,   20'h00359, 5'b11000};
      vecs[1] = '{14'd0,     20'h00000, 5'b11110};
      vecs[2] = '{14'd16383, 20'h16383, 5'b00000};
      vecs[3] = '{14'd1000,  20'h01000, 5'b10000};
      vecs[4] = '{14'd9,     20'h00009, 5'b11110};
      vecs[5] = '{14'd10,    20'h00010, 5'b11100};
      vecs[6] = '{14'd9999,  20'h09999, 5'b10000};
      vecs[7] = '{14'd10000, 20'h10000, 5'b00000};
      vecs[8] = '{14'd100,   20'h00100, 5'b11000};

      i_rst = 1'b0;
      repeat (3) @(posedge i_clk);
      #1;
      chk("reset bcd", 32'(o_bcd), 32'h0);
      chk("reset blank", 32'(o_blank), 32'b11110);
      chk("reset busy", 32'(o_busy), 32'd0);
      chk("reset finished", 32'(o_finished), 32'd0);
      @(negedge i_clk);
      i_rst = 1'b1;
      i_start = 1'bx;
      @(negedge i_clk);
      chk("x start idle busy", 32'(o_busy), 32'd0);
      i_start = 1'b0;

      for (int i = 0; i < 9; i++) begin
         run(vecs[i].deg, vecs[i].bcd, vecs[i].blank, $sformatf("vec%0d", i));
      end

      // Second start during CAL must be ignored.
      @(negedge i_clk);
      i_start = 1'b1;
      i_deg   = 14'd123;
      @(posedge i_clk);
      #1;
      i_start = 1'b0;
      pulses = 0;
      for (int c = 1; c <= 40; c++) begin
         if (c == 5) begin
            i_start = 1'b1;
            i_deg   = 14'd456;
         end else begin
            i_start = 1'b0;
         end
         @(posedge i_clk);
         #1;
         if (o_finished) begin
            pulses++;
            chk("restart latency", 32'(c), 32'd15);
            chk("restart bcd", 32'(o_bcd), 32'h00123);
            chk("restart blank", 32'(o_blank), 32'b11000);
         end
      end
      i_start = 1'b0;
      chk("restart pulses", 32'(pulses), 32'd1);
      chk("restart idle", 32'(o_busy), 32'd0);
      last_bcd = 20'h00123;

      // Reset abort in the middle of CAL.
      @(negedge i_clk);
      i_start = 1'b1;
      i_deg   = 14'd300;
      @(posedge i_clk);
      #1;
      i_start = 1'b0;
      repeat (7) @(posedge i_clk);
      #2;
      i_rst = 1'b0;
      #1;
      chk("abort bcd", 32'(o_bcd), 32'h0);
      chk("abort blank", 32'(o_blank), 32'b11110);
      chk("abort busy", 32'(o_busy), 32'd0);
      pulses = 0;
      for (int c = 0; c < 20; c++) begin
         @(posedge i_clk);
         #1;
         if (c == 3) i_rst = 1'b1;
         if (o_finished) pulses++;
      end
      chk("abort pulses", 32'(pulses), 32'd0);
      last_bcd = 20'h0;
      run(14'd45, 20'h00045, 5'b11100, "post abort");

      // Upstream chain: random values, random idle gaps between finished pulses.
      for (int k = 0; k < 200; k++) begin
         logic [13:0] v;
         logic [19:0] eb;
         v  = 14'($urandom_range(0, 16383));
         eb = bcd_ref(32'(v));
         repeat ($urandom_range(0, 3)) @(posedge i_clk);
         run(v, eb, blank_ref(eb), $sformatf("chain%0d", k));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete, got running expected finished");
      $fatal(1);
   end

endmodule

`default_nettype wire
